// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Interlock partner of the forwarding logic in the 5-stage pipeline. It covers the
//   hazards that forwarding cannot resolve:
//   - load-use: stall F/D and bubble D/X for one cycle
//   - taken control transfer resolved in X: flush F/D and D/X
//   - multi-cycle mul/div in X: pulse a start to multdiv, then hold F/D/X until the
//     result is ready or the hang guard fires
//
// Parameters
//   MD_TIMEOUT  max cycles a mul/div may hold the pipe before a forced release
//   CNT_W       width of the saturating stall-cycle counter
//
// Ports
//   clock           pipeline clock, rising edge
//   reset           asynchronous, active-low
//   IR_D / IR_X     instructions in the D and X stages
//   branch_taken_X  X resolved a taken branch or jump
//   data_resultRDY  multdiv result valid (1-cycle pulse)
//   stall_F/D/X     hold PC, F/D latch, D/X latch
//   bubble_X/M      load nop into D/X, X/M on next edge
//   flush_D         load nop into F/D on next edge
//   ctrl_MULT/DIV   1-cycle multdiv start
//   md_timeout      sticky: mul/div hang guard fired
//   stall_count     saturating count of cycles with stall_F=1
//
// state   | meaning
// IDLE    | no mul/div in flight; load-use and flush rules active
// MD_BUSY | mul/div started, waiting for data_resultRDY or timeout
module hazard_stall_unit #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      IR_D,
  input  logic [31:0]      IR_X,
  input  logic             branch_taken_X,
  input  logic             data_resultRDY,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_X,
  output logic             bubble_X,
  output logic             bubble_M,
  output logic             flush_D,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MDC_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [MDC_W-1:0] MD_LAST = MDC_W'(MD_TIMEOUT - 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t           state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic             set_timeout;

  logic [4:0] op_d, rd_d, rs_d, rt_d;
  logic [4:0] op_x, rd_x;
  logic       reads_rs, reads_rt, reads_rd, reads_r30;
  logic       lw_x, load_use, mul_x, div_x;

  assign op_d = IR_D[31:27];
  assign rd_d = IR_D[26:22];
  assign rs_d = IR_D[21:17];
  assign rt_d = IR_D[16:12];
  assign op_x = IR_X[31:27];
  assign rd_x = IR_X[26:22];

  // Source-register usage of the D-stage instruction.
  assign reads_rs  = op_d inside {OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_JR};
  assign reads_rt  = (op_d == OP_RTYPE);
  assign reads_rd  = op_d inside {OP_SW, OP_BNE, OP_BLT, OP_JR};
  assign reads_r30 = (op_d == OP_BEX);

  assign lw_x     = (op_x == OP_LW) && (rd_x != 5'd0);
  assign load_use = lw_x && ((reads_rs  && (rs_d == rd_x)) ||
                             (reads_rt  && (rt_d == rd_x)) ||
                             (reads_rd  && (rd_d == rd_x)) ||
                             (reads_r30 && (rd_x == 5'd30)));

  assign mul_x = (op_x == OP_RTYPE) && (IR_X[6:2] == ALU_MUL);
  assign div_x = (op_x == OP_RTYPE) && (IR_X[6:2] == ALU_DIV);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      md_cnt      <= '0;
      md_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (set_timeout)
        md_timeout <= 1'b1;
      if (stall_F && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    set_timeout = 1'b0;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_X     = 1'b0;
    bubble_X    = 1'b0;
    bubble_M    = 1'b0;
    flush_D     = 1'b0;
    ctrl_MULT   = 1'b0;
    ctrl_DIV    = 1'b0;
    // Outputs must read 0 while reset is held, even with hazards on the inputs.
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (mul_x || div_x) begin
            ctrl_MULT  = mul_x;
            ctrl_DIV   = div_x;
            stall_F    = 1'b1;
            stall_D    = 1'b1;
            stall_X    = 1'b1;
            bubble_M   = 1'b1;
            md_cnt_nxt = '0;
            state_nxt  = MD_BUSY;
          end else if (branch_taken_X) begin
            flush_D  = 1'b1;
            bubble_X = 1'b1;
          end else if (load_use) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            bubble_X = 1'b1;
          end
        end
        MD_BUSY: begin
          if (data_resultRDY) begin
            state_nxt = IDLE;
          end else if (md_cnt == MD_LAST) begin
            set_timeout = 1'b1;
            state_nxt   = IDLE;
          end else begin
            stall_F    = 1'b1;
            stall_D    = 1'b1;
            stall_X    = 1'b1;
            bubble_M   = 1'b1;
            md_cnt_nxt = md_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 32;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR_D = '0, IR_X = '0;
  logic        branch_taken_X = 1'b0, data_resultRDY = 1'b0;
  logic        stall_F, stall_D, stall_X, bubble_X, bubble_M, flush_D;
  logic        ctrl_MULT, ctrl_DIV, md_timeout;
  logic [CNT_W-1:0] stall_count;
  logic        d2_sF, d2_sD, d2_sX, d2_bX, d2_bM, d2_fD, d2_cM, d2_cD, d2_to;
  logic [2:0]  d2_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  hazard_stall_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .IR_D(IR_D), .IR_X(IR_X),
    .branch_taken_X(branch_taken_X), .data_resultRDY(data_resultRDY),
    .stall_F(stall_F), .stall_D(stall_D), .stall_X(stall_X),
    .bubble_X(bubble_X), .bubble_M(bubble_M), .flush_D(flush_D),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_timeout(md_timeout), .stall_count(stall_count));

  // Narrow counter copy to exercise saturation.
  hazard_stall_unit #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(3)) dut_sat (
    .clock(clock), .reset(reset), .IR_D(IR_D), .IR_X(IR_X),
    .branch_taken_X(branch_taken_X), .data_resultRDY(data_resultRDY),
    .stall_F(d2_sF), .stall_D(d2_sD), .stall_X(d2_sX),
    .bubble_X(d2_bX), .bubble_M(d2_bM), .flush_D(d2_fD),
    .ctrl_MULT(d2_cM), .ctrl_DIV(d2_cD),
    .md_timeout(d2_to), .stall_count(d2_count));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic sF, sD, sX, bX, bM, fD, cM, cD;
  } exp_t;

  bit     m_busy = 0;   // a mul/div has been started and not yet released
  int     m_age  = 0;   // 1-based index of the current waiting cycle
  bit     m_to   = 0;
  longint m_cnt  = 0;

  function automatic bit is_mul(input logic [31:0] ir);
    return ir[31:27] == 5'd0 && ir[6:2] == 5'd6;
  endfunction
  function automatic bit is_div(input logic [31:0] ir);
    return ir[31:27] == 5'd0 && ir[6:2] == 5'd7;
  endfunction

  // Registers the instruction reads, by opcode.
  function automatic bit uses_reg(input logic [31:0] ir, input int r);
    int srcs[$];
    int op = int'(ir[31:27]);
    int rd = int'(ir[26:22]);
    int rs = int'(ir[21:17]);
    int rt = int'(ir[16:12]);
    case (op)
      0:       srcs = '{rs, rt};
      5, 8:    srcs = '{rs};
      2, 6, 7: srcs = '{rs, rd};
      4:       srcs = '{rs, rd};
      22:      srcs = '{30};
      default: srcs = {};
    endcase
    foreach (srcs[i]) if (srcs[i] == r) return 1;
    return 0;
  endfunction

  function automatic bit load_use(input logic [31:0] irx, input logic [31:0] ird);
    int dst = int'(irx[26:22]);
    return irx[31:27] == 5'd8 && dst != 0 && uses_reg(ird, dst);
  endfunction

  function automatic exp_t model_out();
    exp_t e = '0;
    bit hold;
    if (!reset) return e;
    if (m_busy) begin
      hold = !data_resultRDY && (m_age < MD_TIMEOUT);
      e.sF = hold; e.sD = hold; e.sX = hold; e.bM = hold;
    end else if (is_mul(IR_X) || is_div(IR_X)) begin
      e.cM = is_mul(IR_X); e.cD = is_div(IR_X);
      e.sF = 1; e.sD = 1; e.sX = 1; e.bM = 1;
    end else if (branch_taken_X) begin
      e.fD = 1; e.bX = 1;
    end else if (load_use(IR_X, IR_D)) begin
      e.sF = 1; e.sD = 1; e.bX = 1;
    end
    return e;
  endfunction

  always @(posedge clock or negedge reset) begin
    exp_t e;
    if (!reset) begin
      m_busy <= 0; m_age <= 0; m_to <= 0; m_cnt <= 0;
    end else begin
      e = model_out();
      if (e.sF && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (m_busy) begin
        if (data_resultRDY) m_busy <= 0;
        else if (m_age >= MD_TIMEOUT) begin m_busy <= 0; m_to <= 1; end
        else m_age <= m_age + 1;
      end else if (is_mul(IR_X) || is_div(IR_X)) begin
        m_busy <= 1; m_age <= 1;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clock) begin
    exp_t e;
    e = model_out();
    chk("stall_F",   stall_F,   e.sF);
    chk("stall_D",   stall_D,   e.sD);
    chk("stall_X",   stall_X,   e.sX);
    chk("bubble_X",  bubble_X,  e.bX);
    chk("bubble_M",  bubble_M,  e.bM);
    chk("flush_D",   flush_D,   e.fD);
    chk("ctrl_MULT", ctrl_MULT, e.cM);
    chk("ctrl_DIV",  ctrl_DIV,  e.cD);
    chk("md_timeout", md_timeout, m_to);
    chk("stall_count", stall_count, m_cnt);
    chk("sat_outputs", {d2_sF, d2_sD, d2_sX, d2_bX, d2_bM, d2_fD, d2_cM, d2_cD, d2_to},
        {e.sF, e.sD, e.sX, e.bX, e.bM, e.fD, e.cM, e.cD, m_to});
    chk("sat_count", d2_count, (m_cnt > 7) ? 7 : m_cnt);
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] r_type(input int alu, input int rd, input int rs, input int rt);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction
  function automatic logic [31:0] i_type(input int op, input int rd, input int rs);
    return {5'(op), 5'(rd), 5'(rs), 17'd0};
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  // IR_X=lw, IR_D=consumer: stall exactly one cycle, then the bubble clears it.
  task automatic lu_case(input string nm, input logic [31:0] irx, input logic [31:0] ird,
                         input bit exp_stall);
    IR_X = irx; IR_D = ird; branch_taken_X = 0; data_resultRDY = 0;
    #2 chk(nm, {stall_F, stall_D, bubble_X, flush_D}, exp_stall ? 4'b1110 : 4'b0000);
    step();
    IR_X = '0;
    #2 chk({nm, "_after"}, {stall_F, stall_D, bubble_X}, 3'b000);
    step();
    IR_D = '0;
  endtask

  // Runs one mul/div; rdy_at<0 means never ready. Branch is asserted while held.
  task automatic run_md(input logic [31:0] ir, input int rdy_at, input bit br_busy,
                        output int n_stall, output int n_mul, output int n_div,
                        output int n_flush);
    n_stall = 0; n_mul = 0; n_div = 0; n_flush = 0;
    IR_X = ir; IR_D = '0; branch_taken_X = 0;
    for (int k = 0; k < 200; k++) begin
      data_resultRDY = (k == rdy_at);
      branch_taken_X = br_busy && k > 0 && k != rdy_at;
      #2;
      n_stall += int'(stall_X);
      n_mul   += int'(ctrl_MULT);
      n_div   += int'(ctrl_DIV);
      n_flush += int'(flush_D);
      if (k > 0 && !stall_X) begin
        step();
        IR_X = '0; data_resultRDY = 0; branch_taken_X = 0;
        return;
      end
      step();
    end
    chk("md_release_bound", 0, 1);
    IR_X = '0; data_resultRDY = 0; branch_taken_X = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    int ops[11] = '{0, 5, 7, 8, 2, 6, 4, 22, 1, 3, 21};
    int op = ops[$urandom_range(10)];
    int pick[4];
    foreach (pick[i]) pick[i] = ($urandom_range(9) == 0) ? 30 : int'($urandom_range(7));
    if (op == 0) return r_type(int'($urandom_range(7)), pick[0], pick[1], pick[2]);
    return {5'(op), 5'(pick[0]), 5'(pick[1]), 5'(pick[3]), 12'($urandom)};
  endfunction

  initial begin
    int ns, nm, nd, nf;
    longint c0;
    logic [31:0] mul_i, div_i, add_i, lw5;
    mul_i = r_type(6, 3, 1, 2);
    div_i = r_type(7, 4, 1, 2);
    add_i = r_type(0, 6, 5, 7);
    lw5   = i_type(8, 5, 2);

    // reset with hazards present on the inputs
    IR_X = lw5; IR_D = add_i; branch_taken_X = 1;
    repeat (3) step();
    chk("reset_outputs", {stall_F, stall_D, stall_X, bubble_X, bubble_M, flush_D,
                          ctrl_MULT, ctrl_DIV, md_timeout}, 9'd0);
    chk("reset_count", stall_count, 0);
    IR_X = '0; IR_D = '0; branch_taken_X = 0;
    reset = 1;
    step();

    lu_case("lu_rs",   lw5, add_i, 1);
    lu_case("lu_rt",   lw5, r_type(0, 6, 7, 5), 1);
    lu_case("lu_r0",   i_type(8, 0, 2), r_type(0, 6, 0, 0), 0);
    lu_case("lu_bex",  i_type(8, 30, 1), {5'd22, 27'd0}, 1);
    lu_case("lu_sw",   lw5, i_type(7, 5, 2), 1);
    lu_case("lu_none", lw5, r_type(0, 6, 1, 2), 0);

    // flush beats load-use
    IR_X = lw5; IR_D = add_i; branch_taken_X = 1;
    #2 chk("flush_over_lu", {stall_F, stall_D, bubble_X, flush_D}, 4'b0011);
    step();
    IR_X = '0; IR_D = '0; branch_taken_X = 0;

    // mul ready after 17 cycles
    c0 = stall_count;
    run_md(mul_i, 17, 0, ns, nm, nd, nf);
    chk("mul17_stall_cycles", ns, 17);
    chk("mul17_pulses", {nm[7:0], nd[7:0]}, 16'h0100);
    chk("mul17_count", stall_count - c0, 17);

    // div then mul back-to-back
    c0 = stall_count;
    run_md(div_i, 5, 0, ns, nm, nd, nf);
    chk("b2b_div", {ns[7:0], nm[7:0], nd[7:0]}, 24'h050001);
    run_md(mul_i, 3, 0, ns, nm, nd, nf);
    chk("b2b_mul", {ns[7:0], nm[7:0], nd[7:0]}, 24'h030100);
    chk("b2b_count", stall_count - c0, 8);

    // taken branch ignored while mul/div holds X
    run_md(mul_i, 6, 1, ns, nm, nd, nf);
    chk("branch_while_busy", nf, 0);

    // hang guard
    run_md(div_i, -1, 0, ns, nm, nd, nf);
    chk("timeout_stall_cycles", ns, 64);
    chk("timeout_flag", md_timeout, 1);
    repeat (5) step();
    chk("timeout_sticky", {md_timeout, stall_X}, 2'b10);

    // reset in the middle of a busy period
    IR_X = mul_i;
    repeat (4) step();
    #1 reset = 0;
    #1 chk("reset_mid_busy", {stall_F, stall_D, stall_X, bubble_M, ctrl_MULT,
                              md_timeout, stall_count}, '0);
    IR_X = '0;
    step();
    reset = 1;
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      IR_X = rand_instr();
      IR_D = rand_instr();
      branch_taken_X = ($urandom_range(6) == 0);
      data_resultRDY = ($urandom_range(9) == 0);
      reset = ($urandom_range(299) != 0);
      step();
    end
    reset = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
